// File: rtl/digit_encoder_pkg.sv
// Shared constants for the 7-segment to binary digit encoder.
package digit_pkg;

  // Active-low segment patterns, bits {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned ERR_INVALID  = 0;
  localparam int unsigned ERR_OVERFLOW = 1;

  localparam int unsigned OFS_HUND  = 14;
  localparam int unsigned OFS_TENS  = 7;
  localparam int unsigned OFS_UNITS = 0;

endpackage

// File: rtl/digit_encoder_seg_to_digit.sv
// Combinational 7-segment pattern to decimal digit decoder.
module seg_to_digit
  import digit_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       is_blank_o,
  output logic       is_valid_o
);

  logic [6:0] pat;

  // Normalise polarity to active-low, then match against the digit table.
  always_comb begin
    pat        = SEG_ACTIVE_LOW ? seg_i : ~seg_i;
    digit_o    = '0;
    is_valid_o = 1'b1;
    is_blank_o = (pat == SEG_BLANK);
    case (pat)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: is_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/digit_encoder.sv
// Recovers an 8-bit value from three 7-segment digit patterns (hundreds, tens, units).
module digit_encoder
  import digit_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [20:0] CODE,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [7:0]  RAW_CODE,
  output logic [1:0]  ERR,
  output logic        OUT_VALID,
  input  logic        OUT_READY
);

  state_e      state_q, state_d;
  logic [20:0] code_q, code_d;
  logic [9:0]  acc_q, acc_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  flg_q, flg_d;
  logic        lead_q, lead_d;
  logic [7:0]  raw_q, raw_d;
  logic [1:0]  err_q, err_d;

  logic [6:0]  seg_sel;
  logic [3:0]  digit;
  logic        is_blank;
  logic        is_valid;
  logic        blank_ok;
  logic        step_err;
  logic [3:0]  digit_eff;
  logic [9:0]  acc_step;
  logic [1:0]  fin_flags;

  // Select the pattern for the digit currently being accumulated.
  always_comb begin
    case (idx_q)
      2'd2:    seg_sel = code_q[OFS_HUND +: 7];
      2'd1:    seg_sel = code_q[OFS_TENS +: 7];
      default: seg_sel = code_q[OFS_UNITS +: 7];
    endcase
  end

  seg_to_digit #(
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_seg_to_digit (
    .seg_i      (seg_sel),
    .digit_o    (digit),
    .is_blank_o (is_blank),
    .is_valid_o (is_valid)
  );

  // Per-digit value and error, plus the multiply-by-10 accumulate step.
  // lead_q stays set only while every digit so far was blank, so a blank is
  // tolerated only as a leading hundreds/tens digit.
  always_comb begin
    blank_ok  = BLANK_LEADING && lead_q && (idx_q != 2'd0);
    step_err  = (!is_valid && !is_blank) || (is_blank && !blank_ok);
    digit_eff = (is_valid && !is_blank) ? digit : 4'd0;
    acc_step  = (acc_q << 3) + (acc_q << 1) + {6'b0, digit_eff};
    fin_flags = flg_q;
    fin_flags[ERR_INVALID]  = flg_q[ERR_INVALID] | step_err;
    fin_flags[ERR_OVERFLOW] = flg_q[ERR_OVERFLOW] | (acc_step > 10'd255);
  end

  // Next-state logic for IDLE -> ACC (3 steps) -> RESP.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    flg_d   = flg_q;
    lead_d  = lead_q;
    raw_d   = raw_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          code_d  = CODE;
          acc_d   = '0;
          flg_d   = '0;
          idx_d   = 2'd2;
          lead_d  = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d  = acc_step;
        lead_d = lead_q & is_blank;
        flg_d[ERR_INVALID] = flg_q[ERR_INVALID] | step_err;
        if (idx_q == 2'd0) begin
          flg_d   = fin_flags;
          err_d   = fin_flags;
          raw_d   = (fin_flags == 2'b00) ? acc_step[7:0] : 8'h00;
          state_d = RESP;
        end else begin
          idx_d = idx_q - 2'd1;
        end
      end
      RESP: begin
        if (OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      code_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      flg_q   <= '0;
      lead_q  <= 1'b0;
      raw_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      flg_q   <= flg_d;
      lead_q  <= lead_d;
      raw_q   <= raw_d;
      err_q   <= err_d;
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == RESP);
  assign RAW_CODE  = raw_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_digit_encoder.sv
// Self-checking bench for digit_encoder: vector table, corner sequences, random vs model.
module tb_digit_encoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [20:0] CODE = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [7:0]  RAW_CODE;
  logic [1:0]  ERR;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  digit_encoder #(
    .SEG_ACTIVE_LOW (1'b1),
    .BLANK_LEADING  (1'b1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CODE      (CODE),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .RAW_CODE  (RAW_CODE),
    .ERR       (ERR),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [20:0] code;
    logic [7:0]  raw;
    logic [1:0]  err;
  } vec_t;

  logic [6:0] segtab [10];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Reference: decode each field by table lookup and combine with decimal arithmetic.
  task automatic model(input logic [20:0] c, output logic [7:0] raw, output logic [1:0] err);
    int vals [3];
    int total;
    bit inv;
    bit lead;
    logic [6:0] p;
    inv  = 0;
    lead = 1;
    for (int i = 0; i < 3; i++) begin
      p = c[20 - 7*i -: 7];
      vals[i] = 0;
      if (p == 7'h7F) begin
        if (!(lead && i < 2)) inv = 1;
      end else begin
        bit found;
        found = 0;
        lead = 0;
        for (int k = 0; k < 10; k++)
          if (segtab[k] == p) begin vals[i] = k; found = 1; end
        if (!found) inv = 1;
      end
    end
    total = vals[0] * 100 + vals[1] * 10 + vals[2];
    err = {total > 255, inv};
    raw = (err == 2'b00) ? total[7:0] : 8'h00;
  endtask

  // Accept one code, check 3-cycle latency, hold the result `hold` cycles, then consume it.
  task automatic run_conv(input logic [20:0] c, input int hold, input string tag,
                          output logic [7:0] raw, output logic [1:0] err);
    int cnt;
    cnt = 0;
    while (!IN_READY && cnt < 20) begin @(posedge CLK); #1; cnt++; end
    chk({tag, "_in_ready"}, int'(IN_READY), 1);
    CODE = c;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    CODE = 21'($urandom);
    cnt = 0;
    while (!OUT_VALID && cnt < 10) begin @(posedge CLK); #1; cnt++; end
    chk({tag, "_latency"}, cnt, 3);
    raw = RAW_CODE;
    err = ERR;
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      chk({tag, "_hold_raw"}, int'(RAW_CODE), int'(raw));
      chk({tag, "_hold_valid"}, int'(OUT_VALID), 1);
    end
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    chk({tag, "_done_valid"}, int'(OUT_VALID), 0);
    chk({tag, "_done_raw_kept"}, int'(RAW_CODE), int'(raw));
  endtask

  vec_t vecs [9];
  logic [7:0] r, er;
  logic [1:0] e, ee;
  int cnt;

  initial begin
    segtab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    vecs[0] = '{{7'h24, 7'h12, 7'h12}, 8'hFF, 2'b00};
    vecs[1] = '{{7'h24, 7'h12, 7'h02}, 8'h00, 2'b10};
    vecs[2] = '{{7'h10, 7'h10, 7'h10}, 8'h00, 2'b10};
    vecs[3] = '{{7'h7F, 7'h19, 7'h24}, 8'h2A, 2'b00};
    vecs[4] = '{{7'h7F, 7'h7F, 7'h79}, 8'h01, 2'b00};
    vecs[5] = '{{7'h79, 7'h7F, 7'h40}, 8'h00, 2'b01};
    vecs[6] = '{{7'h40, 7'h55, 7'h40}, 8'h00, 2'b01};
    vecs[7] = '{{7'h7F, 7'h7F, 7'h7F}, 8'h00, 2'b01};
    vecs[8] = '{{7'h40, 7'h40, 7'h40}, 8'h00, 2'b00};

    // Reset state
    #1;
    chk("rst_in_ready", int'(IN_READY), 1);
    chk("rst_out_valid", int'(OUT_VALID), 0);
    chk("rst_raw", int'(RAW_CODE), 0);
    chk("rst_err", int'(ERR), 0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Table vectors
    foreach (vecs[i]) begin
      run_conv(vecs[i].code, i % 3, $sformatf("vec%0d", i), r, e);
      chk($sformatf("vec%0d_raw", i), int'(r), int'(vecs[i].raw));
      chk($sformatf("vec%0d_err", i), int'(e), int'(vecs[i].err));
    end

    // "128" stalled 5 cycles while another input is offered
    CODE = {7'h79, 7'h24, 7'h00};
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    CODE = {7'h40, 7'h79, 7'h30};  // "013"
    cnt = 0;
    while (!OUT_VALID && cnt < 10) begin @(posedge CLK); #1; cnt++; end
    chk("stall_latency", cnt, 3);
    for (int h = 0; h < 5; h++) begin
      chk("stall_raw", int'(RAW_CODE), 8'h80);
      chk("stall_valid", int'(OUT_VALID), 1);
      chk("stall_in_ready", int'(IN_READY), 0);
      @(posedge CLK); #1;
    end
    chk("stall_raw_end", int'(RAW_CODE), 8'h80);
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    chk("stall_release_valid", int'(OUT_VALID), 0);
    chk("stall_release_in_ready", int'(IN_READY), 1);
    @(posedge CLK); #1;  // "013" accepted from IDLE here
    IN_VALID = 1'b0;
    chk("next_accepted", int'(IN_READY), 0);
    cnt = 0;
    while (!OUT_VALID && cnt < 10) begin @(posedge CLK); #1; cnt++; end
    chk("next_latency", cnt, 3);
    chk("next_raw", int'(RAW_CODE), 13);
    chk("next_err", int'(ERR), 0);
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;

    // Asynchronous reset between E1 and E2
    CODE = {7'h24, 7'h12, 7'h12};
    IN_VALID = 1'b1;
    @(posedge CLK); #1;     // E0
    IN_VALID = 1'b0;
    @(posedge CLK); #2;     // after E1
    RST = 1'b1;
    #1;
    chk("arst_in_ready", int'(IN_READY), 1);
    chk("arst_out_valid", int'(OUT_VALID), 0);
    chk("arst_raw", int'(RAW_CODE), 0);
    chk("arst_err", int'(ERR), 0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("arst_still_idle", int'(OUT_VALID), 0);
    run_conv({7'h40, 7'h40, 7'h78}, 0, "after_rst", r, e);
    chk("after_rst_raw", int'(r), 7);
    chk("after_rst_err", int'(e), 0);

    // Randomized codes against the reference model
    for (int n = 0; n < 60; n++) begin
      logic [20:0] c;
      for (int f = 0; f < 3; f++) begin
        int sel;
        sel = $urandom_range(0, 11);
        if (sel < 8) c[20 - 7*f -: 7] = segtab[$urandom_range(0, 9)];
        else if (sel < 10) c[20 - 7*f -: 7] = 7'h7F;
        else c[20 - 7*f -: 7] = 7'($urandom);
      end
      model(c, er, ee);
      run_conv(c, $urandom_range(0, 2), $sformatf("rnd%0d", n), r, e);
      chk($sformatf("rnd%0d_raw", n), int'(r), int'(er));
      chk($sformatf("rnd%0d_err", n), int'(e), int'(ee));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/digit_encoder.md
Name: digit_encoder

Overview:
- Reverse path of the I2C display decoder: takes three 7-segment digit patterns (hundreds, tens, units) and recovers the 8-bit binary value they show.
- Patterns come from a segment capture or loopback path. The block checks each pattern, rebuilds the value with a sequential multiply-by-10 accumulate, flags errors, and returns the byte through a valid/ready handshake to the I2C transmit side.

Parameters:
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (board convention); 0 = lit when bit is 1.
- BLANK_LEADING, 1, 1 = an all-off pattern in hundreds, or in tens when hundreds is also blank, counts as 0.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- CODE  input  21  [20:14] hundreds, [13:7] tens, [6:0] units; each field is {g,f,e,d,c,b,a}
- IN_VALID  input  1  CODE is valid
- IN_READY  output  1  block can accept CODE
- RAW_CODE  output  8  recovered binary value
- ERR  output  2  bit0 = invalid segment pattern, bit1 = value > 255
- OUT_VALID  output  1  RAW_CODE and ERR are valid
- OUT_READY  input  1  consumer accepts the result

Behaviour:
- Reset (any time, asynchronous): state = IDLE, IN_READY=1, OUT_VALID=0, RAW_CODE=0, ERR=0, accumulator=0, digit index=0. An operation in flight is dropped silently.
- States: IDLE, ACC, RESP.
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY at edge E0: latch CODE into an internal register, clear the accumulator (10 bits) and the error flags, digit index=2, go to ACC.
  - CODE is not sampled again until the next accept.
- ACC:
  - IN_READY=0. One digit per cycle, most significant first.
  - Each step: acc <= (acc<<3) + (acc<<1) + d, where d is the decoded digit at the current index.
  - Steps occur at E1 (hundreds), E2 (tens), E3 (units). At E3, go to RESP.
- Segment decode, active-low values, bits {g..a}:
  - 0 = 0x40, 1 = 0x79, 2 = 0x24, 3 = 0x30, 4 = 0x19, 5 = 0x12, 6 = 0x02, 7 = 0x78, 8 = 0x00, 9 = 0x10.
  - When SEG_ACTIVE_LOW=0, all patterns are bitwise inverted.
- Blank pattern (all segments off: 0x7F active-low):
  - Is d=0 only under the BLANK_LEADING rule.
  - Blank in units, or blank after a non-blank digit, sets ERR[0].
- Any other unmatched pattern sets ERR[0] and uses d=0.
- Overflow: after the units step, acc > 255 sets ERR[1]. The maximum is 999, which fits in 10 bits.
- RESP:
  - OUT_VALID=1.
  - RAW_CODE = acc[7:0] when ERR==0, else 0x00.
  - ERR holds the final flags. Both errors can be set together; RAW_CODE is then 0.
  - Outputs are registered and stay stable while OUT_VALID=1 and OUT_READY=0.
  - On OUT_READY=1: go to IDLE, OUT_VALID=0. RAW_CODE and ERR keep their last values.
- Latency: OUT_VALID is high in the cycle after E3, which is 3 clocks after the accept edge. Throughput is at most one conversion per 5 cycles.
- Simultaneous events:
  - IN_VALID during ACC or RESP is ignored; IN_READY is 0 there.
  - OUT_READY and IN_VALID high together in RESP: only the output handshake completes. The new input is accepted from IDLE at the next edge.
- OUT_READY while OUT_VALID=0 has no effect.

Decomposition:
- Shared package digit_pkg:
  - 7-bit segment constants SEG_0..SEG_9 and SEG_BLANK.
  - State encoding IDLE/ACC/RESP.
  - ERR bit indices ERR_INVALID=0, ERR_OVERFLOW=1.
  - Digit field offsets 14/7/0.
- Sub-module seg_to_digit (combinational): 7-bit pattern in → 4-bit digit, is_blank, is_valid.
  - It is the inverse of the existing digit-to-segment converter.
  - Instantiated once and fed by a 3:1 mux on the digit index.

Test Plan:
- CODE={0x24,0x12,0x12} ("255") accepted → OUT_VALID 3 clocks later, RAW_CODE=0xFF, ERR=00.
- CODE={0x24,0x12,0x02} ("256") → RAW_CODE=0x00, ERR=10. CODE={0x10,0x10,0x10} ("999") → RAW_CODE=0x00, ERR=10.
- CODE={0x7F,0x19,0x24} (" 42") → RAW_CODE=0x2A, ERR=00. CODE={0x7F,0x7F,0x79} → RAW_CODE=0x01.
- CODE={0x79,0x7F,0x40} (blank after a digit) → ERR[0]=1. CODE={0x40,0x55,0x40} (bad tens) → ERR=01, RAW_CODE=0.
- "128" = {0x79,0x24,0x00} with OUT_READY held low 5 cycles:
  - RAW_CODE=0x80 and OUT_VALID stay stable, and IN_READY=0 throughout.
  - A new IN_VALID during this time is not accepted.
  - Raising OUT_READY returns the block to IDLE, and the next item is processed correctly.
- RST asserted asynchronously during ACC (between E1 and E2) → all outputs 0 and IN_READY=1 immediately. The next conversion of "007" {0x40,0x40,0x78} gives 0x07.
